// File: rtl/mem_io_responder_pkg.sv
// mem_io_pkg: address map, read-source and stop-state encodings for mem_io_responder.
package mem_io_pkg;
    localparam logic [17:0] IO_BASE_MASK = 18'h30000;
    localparam logic [17:0] ADDR_UART = 18'h30000;
    localparam logic [17:0] ADDR_CLK = 18'h30004;

    typedef enum logic [1:0] {SRC_RAM, SRC_RX, SRC_CNT, SRC_ZERO} src_e;
    typedef enum logic [1:0] {RUN, STOPPING, STOPPED} state_e;

    function automatic logic is_io(input logic [17:0] a);
        return (a & IO_BASE_MASK) == IO_BASE_MASK;
    endfunction
endpackage

// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if: CPU byte bus plus UART byte streams seen by the responder.
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        program_stop;

    modport slave (
        input  mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
        output mem_din, io_buffer_full, tx_data, tx_valid, program_stop
    );
    modport master (
        output mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
        input  mem_din, io_buffer_full, tx_data, tx_valid, program_stop
    );
endinterface

// File: rtl/mem_io_responder_fifo.sv
// byte_fifo: byte queue with first-word-fall-through head; push while full succeeds only alongside a pop.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_pop;
    logic          do_push;

    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign head = mem[rp];
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: RAM with one-cycle reads plus an I/O window holding UART queues,
// a cycle counter with coherent 4-byte snapshot, and a terminator-based program stop.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int FULL_MARGIN = 4
) (
    input logic                 clk_in,
    input logic                 rst_in,
    mem_io_responder_if.slave   bus
);
    localparam int TW = $clog2(TX_DEPTH) + 1;
    localparam int RW = $clog2(RX_DEPTH) + 1;

    logic [7:0]  ram [2**RAM_ADDR_W];
    logic [17:0] a;
    logic        io;
    logic        ram_we;
    logic [31:0] cnt;
    logic [31:0] snap;
    state_e      state;
    logic        term_pend;
    logic        stop_wr;
    logic        uart_wr;
    logic        term_req;
    logic        tx_push;
    logic [7:0]  tx_push_data;
    logic        tx_pop;
    logic        tx_ok;
    logic        tx_full;
    logic        tx_empty;
    logic [TW-1:0] tx_count;
    logic [TW-1:0] tx_cnt_nxt;
    logic        rx_pop;
    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  rx_head;
    logic [RW-1:0] rx_count;
    src_e        src;
    logic [7:0]  cnt_byte;
    logic [7:0]  rd;
    logic        unused_bits;

    assign unused_bits = ^{bus.mem_a[31:18], rx_full, rx_count};
    assign a = bus.mem_a[17:0];
    assign io = is_io(a);
    assign ram_we = bus.mem_wr && !io;

    // The terminator outranks a same-cycle UART write and keeps retrying until the queue takes it.
    assign stop_wr = io && bus.mem_wr && a == ADDR_CLK && state == RUN;
    assign uart_wr = io && bus.mem_wr && a == ADDR_UART && state != STOPPED && bus.mem_dout != 8'h00;
    assign term_req = stop_wr || term_pend;
    assign tx_push = term_req || uart_wr;
    assign tx_push_data = term_req ? 8'h00 : bus.mem_dout;
    assign tx_pop = !tx_empty && bus.tx_ready;
    assign tx_ok = tx_push && (!tx_full || tx_pop);
    assign tx_cnt_nxt = tx_count + TW'(tx_ok) - TW'(tx_pop);
    assign rx_pop = io && !bus.mem_wr && a == ADDR_UART && !rx_empty;
    assign bus.tx_valid = !tx_empty;

    assign src = bus.mem_wr ? SRC_ZERO :
                 !io ? SRC_RAM :
                 a == ADDR_UART ? SRC_RX :
                 a[17:2] == ADDR_CLK[17:2] ? SRC_CNT : SRC_ZERO;
    // Byte 0 reads the live counter; bytes 1..3 come from the snapshot taken with byte 0.
    assign cnt_byte = a[1:0] == 2'd0 ? cnt[7:0] : snap[{a[1:0], 3'b000} +: 8];
    assign rd = src == SRC_RAM ? ram[bus.mem_a[RAM_ADDR_W-1:0]] :
                src == SRC_RX ? (rx_empty ? 8'h00 : rx_head) :
                src == SRC_CNT ? cnt_byte : 8'h00;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx (
        .clk(clk_in), .rst(rst_in), .push(tx_push), .push_data(tx_push_data), .pop(tx_pop),
        .head(bus.tx_data), .empty(tx_empty), .full(tx_full), .count(tx_count)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx (
        .clk(clk_in), .rst(rst_in), .push(bus.rx_valid), .push_data(bus.rx_data), .pop(rx_pop),
        .head(rx_head), .empty(rx_empty), .full(rx_full), .count(rx_count)
    );

    always_ff @(posedge clk_in) begin
        if (ram_we) ram[bus.mem_a[RAM_ADDR_W-1:0]] <= bus.mem_dout;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus.mem_din <= 8'h00;
            bus.io_buffer_full <= 1'b0;
            bus.program_stop <= 1'b0;
            cnt <= '0;
            snap <= '0;
            state <= RUN;
            term_pend <= 1'b0;
        end else begin
            bus.mem_din <= rd;
            cnt <= cnt + 32'd1;
            if (src == SRC_CNT && a[1:0] == 2'd0) snap <= cnt;
            bus.io_buffer_full <= tx_cnt_nxt >= TW'(TX_DEPTH - FULL_MARGIN);
            term_pend <= term_req && !tx_ok;
            if (stop_wr) begin
                state <= STOPPING;
            end else if (state == STOPPING && !term_req && tx_cnt_nxt == '0) begin
                state <= STOPPED;
                bus.program_stop <= 1'b1;
            end
        end
    end
endmodule
